// File: rtl/des_key_schedule_pkg.sv
`default_nettype none
// ============================================================================
// Module   : des_key_schedule_pkg
// Purpose  : Shared DES key-schedule definitions. Holds the width constants,
//            the PC-1 / PC-2 selection tables, the per-round shift table, the
//            schedule FSM state type and small helpers for PC-1, the 28-bit
//            rotations and key-byte parity.
// Tables   : entries use DES bit numbering (1 = MSB of the source vector).
// Revision : 1.0 - initial release
// ============================================================================
package des_key_schedule_pkg;

    localparam int KEY_W      = 64;
    localparam int HALF_W     = 28;
    localparam int CD_W       = 2 * HALF_W;
    localparam int SUBKEY_W   = 48;
    localparam int ROUND_W    = 4;
    localparam int NUM_ROUNDS = 16;

    // PC-1: 64-bit key -> 56-bit C||D (parity bits 8,16,...,64 dropped)
    localparam logic [5:0] PC1_TAB [56] = '{
        6'd57, 6'd49, 6'd41, 6'd33, 6'd25, 6'd17, 6'd9,
        6'd1,  6'd58, 6'd50, 6'd42, 6'd34, 6'd26, 6'd18,
        6'd10, 6'd2,  6'd59, 6'd51, 6'd43, 6'd35, 6'd27,
        6'd19, 6'd11, 6'd3,  6'd60, 6'd52, 6'd44, 6'd36,
        6'd63, 6'd55, 6'd47, 6'd39, 6'd31, 6'd23, 6'd15,
        6'd7,  6'd62, 6'd54, 6'd46, 6'd38, 6'd30, 6'd22,
        6'd14, 6'd6,  6'd61, 6'd53, 6'd45, 6'd37, 6'd29,
        6'd21, 6'd13, 6'd5,  6'd28, 6'd20, 6'd12, 6'd4
    };

    // PC-2: 56-bit C||D -> 48-bit subkey
    localparam logic [5:0] PC2_TAB [48] = '{
        6'd14, 6'd17, 6'd11, 6'd24, 6'd1,  6'd5,
        6'd3,  6'd28, 6'd15, 6'd6,  6'd21, 6'd10,
        6'd23, 6'd19, 6'd12, 6'd4,  6'd26, 6'd8,
        6'd16, 6'd7,  6'd27, 6'd20, 6'd13, 6'd2,
        6'd41, 6'd52, 6'd31, 6'd37, 6'd47, 6'd55,
        6'd30, 6'd40, 6'd51, 6'd45, 6'd33, 6'd48,
        6'd44, 6'd49, 6'd39, 6'd56, 6'd34, 6'd53,
        6'd46, 6'd42, 6'd50, 6'd36, 6'd29, 6'd32
    };

    // Rotation applied when entering round r (0-based). The same table serves
    // decrypt order: entering decrypt round r rotates right by SHIFT_TAB[r],
    // which undoes encrypt round 16-r.
    localparam logic [1:0] SHIFT_TAB [16] = '{
        2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
        2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
    };

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_ROUND = 1'b1
    } state_t;

    function automatic logic [CD_W-1:0] des_pc1(input logic [KEY_W-1:0] key);
        logic [CD_W-1:0] cd;
        logic [5:0]      src;
        logic [5:0]      dst;
        cd = '0;
        for (int i = 0; i < CD_W; i++) begin
            src     = 6'(KEY_W - int'(PC1_TAB[i]));
            dst     = 6'(CD_W - 1 - i);
            cd[dst] = key[src];
        end
        return cd;
    endfunction

    // Amount is always 1 or 2 in the DES schedule.
    function automatic logic [HALF_W-1:0] rotl28(input logic [HALF_W-1:0] x,
                                                input logic [1:0]        amt);
        return (amt == 2'd2) ? {x[HALF_W-3:0], x[HALF_W-1:HALF_W-2]}
                             : {x[HALF_W-2:0], x[HALF_W-1]};
    endfunction

    function automatic logic [HALF_W-1:0] rotr28(input logic [HALF_W-1:0] x,
                                                input logic [1:0]        amt);
        return (amt == 2'd2) ? {x[1:0], x[HALF_W-1:2]}
                             : {x[0], x[HALF_W-1:1]};
    endfunction

    // DES keys carry odd parity in every byte.
    function automatic logic des_key_parity_ok(input logic [KEY_W-1:0] key);
        return (^key[63:56]) & (^key[55:48]) & (^key[47:40]) & (^key[39:32]) &
               (^key[31:24]) & (^key[23:16]) & (^key[15:8])  & (^key[7:0]);
    endfunction

endpackage : des_key_schedule_pkg
`default_nettype wire

// File: rtl/des_key_pc2.sv
`default_nettype none
// ============================================================================
// Module   : des_key_pc2
// Purpose  : Combinational DES PC-2 selection, 56-bit C||D -> 48-bit subkey.
// Ports    : i_cd     - C (bits 55:28) concatenated with D (bits 27:0)
//            o_subkey - selected 48-bit round key, DES bit 1 at MSB
// Revision : 1.0 - initial release
// ============================================================================
module des_key_pc2
    import des_key_schedule_pkg::*;
(
    input  logic [CD_W-1:0]     i_cd,
    output logic [SUBKEY_W-1:0] o_subkey
);

    for (genvar g = 0; g < SUBKEY_W; g++) begin : g_pc2
        assign o_subkey[SUBKEY_W-1-g] = i_cd[CD_W - int'(PC2_TAB[g])];
    end

endmodule : des_key_pc2
`default_nettype wire

// File: rtl/des_key_schedule.sv
`default_nettype none
// ============================================================================
// Module   : des_key_schedule
// Purpose  : Sequential DES round-key generator. Loads a 64-bit key, applies
//            PC-1 once, then walks C/D through the per-round rotations and
//            emits PC-2(C,D) one subkey at a time under a valid/ack handshake,
//            in encrypt (K1..K16) or decrypt (K16..K1) order.
// Ports    : clk_i, rst_n_i     - clock, asynchronous active-low reset
//            key_i, decrypt_i   - key and direction, sampled on accepted start
//            start_i / ready_o  - load request / idle indication
//            subkey_o, round_o  - current subkey and its emission index
//            subkey_valid_o     - subkey_o / round_o valid, held until ack_i
//            ack_i              - consumer took the current subkey
//            key_err_o          - key parity failure flag
// Config   : DES_KEY_PARITY_CHECK_EN - when defined, a start with any key
//            byte of even parity is refused and key_err_o is raised until the
//            next accepted start. Undefined: key_err_o is tied low.
// Revision : 1.0 - initial release
// ============================================================================
module des_key_schedule
    import des_key_schedule_pkg::*;
(
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic [KEY_W-1:0]    key_i,
    input  logic                decrypt_i,
    input  logic                start_i,
    input  logic                ack_i,
    output logic                ready_o,
    output logic [SUBKEY_W-1:0] subkey_o,
    output logic                subkey_valid_o,
    output logic [ROUND_W-1:0]  round_o,
    output logic                key_err_o
);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [HALF_W-1:0]     r_c;
    logic [HALF_W-1:0]     r_d;
    logic [HALF_W-1:0]     w_c_nxt;
    logic [HALF_W-1:0]     w_d_nxt;
    logic [ROUND_W-1:0]    r_round;
    logic [ROUND_W-1:0]    w_round_nxt;
    logic [ROUND_W-1:0]    w_round_inc;
    logic                  r_dec;
    logic                  r_ready;
    logic                  r_valid;
    logic [SUBKEY_W-1:0]   r_subkey;
    logic [SUBKEY_W-1:0]   w_subkey;
    logic [CD_W-1:0]       w_pc1;
    logic [1:0]            w_shift;
    logic                  w_par_ok;
    logic                  w_load;
    logic                  w_adv;

    assign w_pc1       = des_pc1(key_i);
    assign w_round_inc = r_round + 4'd1;
    // At round 15 the increment wraps to 0; that shift is never used because
    // the final ack returns to IDLE without rotating.
    assign w_shift     = SHIFT_TAB[w_round_inc];

`ifdef DES_KEY_PARITY_CHECK_EN
    assign w_par_ok = des_key_parity_ok(key_i);
`else
    assign w_par_ok = 1'b1;
`endif

    // Next-state and next-datapath logic. C/D always hold the halves that
    // produced the currently presented subkey, so the subkey register is
    // loaded from PC-2 of the next C/D in the same edge.
    always_comb begin
        w_state_nxt = r_state;
        w_round_nxt = r_round;
        w_c_nxt     = r_c;
        w_d_nxt     = r_d;
        w_load      = 1'b0;
        w_adv       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start_i && w_par_ok) begin
                    w_load      = 1'b1;
                    w_state_nxt = ST_ROUND;
                    w_round_nxt = '0;
                    if (decrypt_i) begin
                        // K16 comes from C0/D0 directly (total shift is 28)
                        w_c_nxt = w_pc1[CD_W-1:HALF_W];
                        w_d_nxt = w_pc1[HALF_W-1:0];
                    end else begin
                        w_c_nxt = rotl28(w_pc1[CD_W-1:HALF_W], 2'd1);
                        w_d_nxt = rotl28(w_pc1[HALF_W-1:0], 2'd1);
                    end
                end
            end
            ST_ROUND: begin
                if (ack_i) begin
                    if (r_round == ROUND_W'(NUM_ROUNDS - 1)) begin
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_adv       = 1'b1;
                        w_round_nxt = w_round_inc;
                        if (r_dec) begin
                            w_c_nxt = rotr28(r_c, w_shift);
                            w_d_nxt = rotr28(r_d, w_shift);
                        end else begin
                            w_c_nxt = rotl28(r_c, w_shift);
                            w_d_nxt = rotl28(r_d, w_shift);
                        end
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    des_key_pc2 u_pc2 (
        .i_cd     ({w_c_nxt, w_d_nxt}),
        .o_subkey (w_subkey)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_c      <= '0;
            r_d      <= '0;
            r_round  <= '0;
            r_dec    <= 1'b0;
            r_ready  <= 1'b1;
            r_valid  <= 1'b0;
            r_subkey <= '0;
        end else begin
            r_c     <= w_c_nxt;
            r_d     <= w_d_nxt;
            r_round <= w_round_nxt;
            r_ready <= (w_state_nxt == ST_IDLE);
            r_valid <= (w_state_nxt == ST_ROUND);
            if (w_load) begin
                r_dec <= decrypt_i;
            end
            if (w_load || w_adv) begin
                r_subkey <= w_subkey;
            end
        end
    end

`ifdef DES_KEY_PARITY_CHECK_EN
    logic r_key_err;
    logic w_par_fail;

    assign w_par_fail = (r_state == ST_IDLE) && start_i && !w_par_ok;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_key_err <= 1'b0;
        end else if (w_load) begin
            r_key_err <= 1'b0;
        end else if (w_par_fail) begin
            r_key_err <= 1'b1;
        end
    end

    assign key_err_o = r_key_err;
`else
    assign key_err_o = 1'b0;
`endif

    assign ready_o        = r_ready;
    assign subkey_valid_o = r_valid;
    assign subkey_o       = r_subkey;
    assign round_o        = r_round;

endmodule : des_key_schedule
`default_nettype wire

// File: tb/tb_des_key_schedule.sv
`default_nettype none
// ============================================================================
// Module   : tb_des_key_schedule
// Purpose  : Self-checking bench for des_key_schedule. A reference model
//            derives every subkey from the cumulative rotation count; expected
//            subkeys are queued when a start is driven and popped as the DUT
//            presents them.
// Config   : DES_KEY_PARITY_CHECK_EN selects the parity-refusal scenario.
// Revision : 1.0 - initial release
// ============================================================================
module tb_des_key_schedule;

    localparam logic [63:0] K_GOOD = 64'h133457799BBCDFF1;
    localparam logic [63:0] K_BAD  = 64'h123457799BBCDFF1;
    localparam logic [47:0] SK_K1  = 48'h1B02EFFC7072;
    localparam logic [47:0] SK_K16 = 48'hCB3D8B0E17F5;

    localparam int M_PC1 [56] = '{
        57, 49, 41, 33, 25, 17, 9,  1,  58, 50, 42, 34, 26, 18,
        10, 2,  59, 51, 43, 35, 27, 19, 11, 3,  60, 52, 44, 36,
        63, 55, 47, 39, 31, 23, 15, 7,  62, 54, 46, 38, 30, 22,
        14, 6,  61, 53, 45, 37, 29, 21, 13, 5,  28, 20, 12, 4
    };
    localparam int M_PC2 [48] = '{
        14, 17, 11, 24, 1,  5,  3,  28, 15, 6,  21, 10,
        23, 19, 12, 4,  26, 8,  16, 7,  27, 20, 13, 2,
        41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
        44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
    };

    typedef struct packed {
        logic [3:0]  rnd;
        logic [47:0] key;
    } sb_t;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic [63:0] key_i;
    logic        decrypt_i;
    logic        start_i;
    logic        ack_i;
    logic        ready_o;
    logic [47:0] subkey_o;
    logic        subkey_valid_o;
    logic [3:0]  round_o;
    logic        key_err_o;

    sb_t         sb [$];
    logic [47:0] seen [16];
    int          n_assert = 0;
    int          n_fail   = 0;

    always #5 clk_i = ~clk_i;

    des_key_schedule dut (
        .clk_i          (clk_i),
        .rst_n_i        (rst_n_i),
        .key_i          (key_i),
        .decrypt_i      (decrypt_i),
        .start_i        (start_i),
        .ack_i          (ack_i),
        .ready_o        (ready_o),
        .subkey_o       (subkey_o),
        .subkey_valid_o (subkey_valid_o),
        .round_o        (round_o),
        .key_err_o      (key_err_o)
    );

    // ---------------- reference model ----------------
    function automatic logic [27:0] m_rotl(input logic [27:0] x, input int n);
        logic [27:0] r;
        r = x;
        for (int i = 0; i < n; i++) r = {r[26:0], r[27]};
        return r;
    endfunction

    // Subkey K<idx>, idx = 1..16, from the total left shift applied to C0/D0
    function automatic logic [47:0] m_subkey(input logic [63:0] k, input int idx);
        logic [55:0] cd;
        logic [27:0] c;
        logic [27:0] d;
        logic [47:0] r;
        int          cum;
        cum = 0;
        for (int j = 1; j <= idx; j++) cum += (j == 1 || j == 2 || j == 9 || j == 16) ? 1 : 2;
        for (int i = 0; i < 56; i++) cd[55 - i] = k[64 - M_PC1[i]];
        c  = m_rotl(cd[55:28], cum % 28);
        d  = m_rotl(cd[27:0], cum % 28);
        cd = {c, d};
        for (int i = 0; i < 48; i++) r[47 - i] = cd[56 - M_PC2[i]];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " ready"},  64'(ready_o),        64'd1);
        chk({tag, " valid"},  64'(subkey_valid_o), 64'd0);
        chk({tag, " subkey"}, 64'(subkey_o),       64'd0);
        chk({tag, " round"},  64'(round_o),        64'd0);
        chk({tag, " keyerr"}, 64'(key_err_o),      64'd0);
    endtask

    // Runs one schedule from the current negedge. hold_rnd: round at which ack
    // is withheld for hold_n cycles; abort_rnd: round at which reset is pulsed.
    task automatic run_seq(input logic [63:0] key, input logic dec,
                           input int hold_rnd, input int hold_n, input int abort_rnd);
        sb_t  e;
        logic aborted;
        aborted = 1'b0;
        for (int r = 0; r < 16; r++) begin
            e.rnd = 4'(r);
            e.key = m_subkey(key, dec ? 16 - r : r + 1);
            sb.push_back(e);
        end
        start_i   = 1'b1;
        key_i     = key;
        decrypt_i = dec;
        ack_i     = 1'b1;          // ack alongside start must be ignored
        @(negedge clk_i);
        start_i   = 1'b0;
        key_i     = ~key;          // later key/direction changes have no effect
        decrypt_i = ~dec;
        for (int r = 0; r < 16; r++) begin
            e = sb.pop_front();
            chk("valid",  64'(subkey_valid_o), 64'd1);
            chk("round",  64'(round_o),        64'(e.rnd));
            chk("subkey", 64'(subkey_o),       64'(e.key));
            seen[r] = subkey_o;
            if (r == 0) begin
                chk("ready_busy", 64'(ready_o),   64'd0);
                chk("keyerr_ok",  64'(key_err_o), 64'd0);
            end
            if (r == abort_rnd) begin
                rst_n_i = 1'b0;
                #1;
                chk_reset_vals("abort");
                sb.delete();
                ack_i = 1'b0;
                @(negedge clk_i);
                rst_n_i = 1'b1;
                aborted = 1'b1;
                break;
            end
            if (r == hold_rnd) begin
                ack_i = 1'b0;
                for (int h = 0; h < hold_n; h++) begin
                    start_i = (h % 2 == 0);   // restart attempts while busy
                    @(negedge clk_i);
                    chk("hold_valid",  64'(subkey_valid_o), 64'd1);
                    chk("hold_round",  64'(round_o),        64'(e.rnd));
                    chk("hold_subkey", 64'(subkey_o),       64'(e.key));
                end
                start_i = 1'b0;
            end
            ack_i = 1'b1;
            @(negedge clk_i);
        end
        if (!aborted) begin
            ack_i = 1'b0;
            chk("ready_end", 64'(ready_o),        64'd1);
            chk("valid_end", 64'(subkey_valid_o), 64'd0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n_i   = 1'b0;
        key_i     = '0;
        decrypt_i = 1'b0;
        start_i   = 1'b0;
        ack_i     = 1'b0;
        repeat (3) @(negedge clk_i);
        chk_reset_vals("reset");
        ack_i = 1'b1;              // ack in IDLE is ignored
        rst_n_i = 1'b1;
        @(negedge clk_i);
        chk_reset_vals("idle_ack");
        ack_i = 1'b0;

        // encrypt, ack every cycle
        run_seq(K_GOOD, 1'b0, -1, 0, -1);
        chk("enc_k1",  64'(seen[0]),  64'(SK_K1));
        chk("enc_k16", 64'(seen[15]), 64'(SK_K16));

        // decrypt, started on the cycle ready returns
        run_seq(K_GOOD, 1'b1, -1, 0, -1);
        chk("dec_r0",  64'(seen[0]),  64'(SK_K16));
        chk("dec_r15", 64'(seen[15]), 64'(SK_K1));

        // ack withheld 5 cycles at round 3, restart pulses ignored
        run_seq(K_GOOD, 1'b0, 3, 5, -1);

        // reset at round 7, then a clean restart
        run_seq(K_GOOD, 1'b0, -1, 0, 7);
        run_seq(K_GOOD, 1'b1, -1, 0, -1);

`ifdef DES_KEY_PARITY_CHECK_EN
        start_i = 1'b1;
        key_i   = K_BAD;
        @(negedge clk_i);
        start_i = 1'b0;
        chk("par_valid",  64'(subkey_valid_o), 64'd0);
        chk("par_ready",  64'(ready_o),        64'd1);
        chk("par_keyerr", 64'(key_err_o),      64'd1);
        @(negedge clk_i);
        chk("par_keyerr_hold", 64'(key_err_o), 64'd1);
        run_seq(K_GOOD, 1'b0, -1, 0, -1);
        chk("par_clear", 64'(key_err_o), 64'd0);
`else
        run_seq(K_BAD, 1'b0, -1, 0, -1);
        chk("nopar_k1",     64'(seen[0]),   64'(SK_K1));
        chk("nopar_k16",    64'(seen[15]),  64'(SK_K16));
        chk("nopar_keyerr", 64'(key_err_o), 64'd0);
`endif

        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_des_key_schedule
`default_nettype wire
